// File: rtl/rv_reg_file_if.sv
// Register file access bundle: two read ports and one write port.
// Master drives indices and write data; slave returns read data.
interface rv_reg_file_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic [ADDR_WIDTH-1:0] read_reg1;
   logic [ADDR_WIDTH-1:0] read_reg2;
   logic [ADDR_WIDTH-1:0] write_reg;
   logic [DATA_WIDTH-1:0] write_data;
   logic                  regwrite;
   logic [DATA_WIDTH-1:0] read_data1;
   logic [DATA_WIDTH-1:0] read_data2;

   modport master (
      output read_reg1,
      output read_reg2,
      output write_reg,
      output write_data,
      output regwrite,
      input  read_data1,
      input  read_data2
   );

   modport slave (
      input  read_reg1,
      input  read_reg2,
      input  write_reg,
      input  write_data,
      input  regwrite,
      output read_data1,
      output read_data2
   );
endinterface

// File: rtl/rv_reg_file.sv
// RISC-V integer register file: 2 async read ports, 1 sync write port.
// x0 is hardwired to zero on both read ports.
module rv_reg_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_REGS   = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   rv_reg_file_if.slave rf
);
   logic [DATA_WIDTH-1:0] registers [0:NUM_REGS-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            registers[i] <= '0;
         end
      end else if (rf.regwrite && (rf.write_reg != '0)) begin
         registers[rf.write_reg] <= rf.write_data;
      end
   end

   // Masking on read keeps x0 zero even if the array entry is forced.
   assign rf.read_data1 = (rf.read_reg1 == '0) ? '0
                        : registers[rf.read_reg1];
   assign rf.read_data2 = (rf.read_reg2 == '0) ? '0
                        : registers[rf.read_reg2];
endmodule

// File: tb/tb_rv_reg_file.sv
// Self-checking bench for rv_reg_file against an array model.
// Directed scenarios followed by randomized read/write traffic.
module tb_rv_reg_file;
   logic clk;
   logic rst_n;
   int   errors;
   int   checks;
   logic [31:0] model [0:31];

   rv_reg_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf ();

   rv_reg_file #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(5),
      .NUM_REGS(32)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rf(rf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_read(input int idx);
      if (idx == 0) return 32'h0;
      return model[idx];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
   endtask

   task automatic test_reset();
      int idx [4];
      idx = '{0, 1, 17, 31};
      rst_n = 1'b1;
      rf.regwrite = 1'b0;
      rf.write_reg = '0;
      rf.write_data = '0;
      rf.read_reg1 = '0;
      rf.read_reg2 = '0;
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         rf.read_reg1 = idx[k][4:0];
         rf.read_reg2 = idx[k][4:0];
         #1;
         checks++;
         if (rf.read_data1 !== 32'h0) begin
            errors++;
            $display("FAIL reset rd1 idx=%0d got=%h exp=%h",
                     idx[k], rf.read_data1, 32'h0);
         end
         checks++;
         if (rf.read_data2 !== 32'h0) begin
            errors++;
            $display("FAIL reset rd2 idx=%0d got=%h exp=%h",
                     idx[k], rf.read_data2, 32'h0);
         end
      end
      repeat (2) tick();
      @(negedge clk);
      rst_n = 1'b1;
      clear_model();
   endtask

   task automatic test_preload();
      for (int i = 0; i < 32; i++) begin
         dut.registers[i] = 32'(i);
         model[i] = 32'(i);
      end
      rf.read_reg1 = 5'd1;
      rf.read_reg2 = 5'd2;
      #1;
      checks++;
      if (rf.read_data1 !== 32'h1) begin
         errors++;
         $display("FAIL preload rd1 got=%h exp=%h",
                  rf.read_data1, 32'h1);
      end
      checks++;
      if (rf.read_data2 !== 32'h2) begin
         errors++;
         $display("FAIL preload rd2 got=%h exp=%h",
                  rf.read_data2, 32'h2);
      end
   endtask

   task automatic test_write_read();
      rf.regwrite = 1'b1;
      rf.write_reg = 5'd3;
      rf.write_data = 32'h1111;
      tick();
      model[3] = 32'h1111;
      rf.read_reg2 = 5'd3;
      #1;
      checks++;
      if (rf.read_data2 !== 32'h0000_1111) begin
         errors++;
         $display("FAIL wr_rd reg3 got=%h exp=%h",
                  rf.read_data2, 32'h0000_1111);
      end
      rf.write_reg = 5'd1;
      rf.write_data = 32'h2222;
      rf.read_reg1 = 5'd1;
      #1;
      checks++;
      if (rf.read_data1 !== 32'h0000_0001) begin
         errors++;
         $display("FAIL wr_rd old got=%h exp=%h",
                  rf.read_data1, 32'h0000_0001);
      end
      tick();
      model[1] = 32'h2222;
      checks++;
      if (rf.read_data1 !== 32'h0000_2222) begin
         errors++;
         $display("FAIL wr_rd new got=%h exp=%h",
                  rf.read_data1, 32'h0000_2222);
      end
      rf.regwrite = 1'b0;
   endtask

   task automatic test_x0();
      rf.regwrite = 1'b1;
      rf.write_reg = 5'd0;
      rf.write_data = 32'hDEAD_BEEF;
      tick();
      rf.regwrite = 1'b0;
      rf.read_reg1 = 5'd0;
      rf.read_reg2 = 5'd0;
      #1;
      checks++;
      if (rf.read_data1 !== 32'h0) begin
         errors++;
         $display("FAIL x0_write got=%h exp=%h",
                  rf.read_data1, 32'h0);
      end
      dut.registers[0] = 32'd5;
      #1;
      checks++;
      if (rf.read_data1 !== 32'h0) begin
         errors++;
         $display("FAIL x0_force rd1 got=%h exp=%h",
                  rf.read_data1, 32'h0);
      end
      checks++;
      if (rf.read_data2 !== 32'h0) begin
         errors++;
         $display("FAIL x0_force rd2 got=%h exp=%h",
                  rf.read_data2, 32'h0);
      end
   endtask

   task automatic test_write_enable();
      rf.regwrite = 1'b0;
      rf.write_reg = 5'd4;
      rf.write_data = 32'hFFFF_FFFF;
      rf.read_reg1 = 5'd4;
      repeat (2) tick();
      checks++;
      if (rf.read_data1 !== ref_read(4)) begin
         errors++;
         $display("FAIL wen_off got=%h exp=%h",
                  rf.read_data1, ref_read(4));
      end
   endtask

   task automatic test_async_reset();
      int idx [3];
      idx = '{1, 31, 17};
      for (int i = 1; i < 32; i++) begin
         dut.registers[i] = $urandom | 32'h1;
      end
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         rf.read_reg1 = idx[k][4:0];
         rf.read_reg2 = idx[k][4:0];
         #1;
         checks++;
         if (rf.read_data1 !== 32'h0) begin
            errors++;
            $display("FAIL arst rd1 idx=%0d got=%h exp=%h",
                     idx[k], rf.read_data1, 32'h0);
         end
         checks++;
         if (rf.read_data2 !== 32'h0) begin
            errors++;
            $display("FAIL arst rd2 idx=%0d got=%h exp=%h",
                     idx[k], rf.read_data2, 32'h0);
         end
      end
      rf.regwrite = 1'b1;
      rf.write_reg = 5'd5;
      rf.write_data = 32'h1234_5678;
      rf.read_reg1 = 5'd5;
      tick();
      checks++;
      if (rf.read_data1 !== 32'h0) begin
         errors++;
         $display("FAIL arst_wr got=%h exp=%h",
                  rf.read_data1, 32'h0);
      end
      @(negedge clk);
      rf.regwrite = 1'b0;
      rst_n = 1'b1;
      clear_model();
   endtask

   task automatic test_dual_read();
      rf.regwrite = 1'b1;
      rf.write_reg = 5'd31;
      rf.write_data = 32'hA5A5_A5A5;
      tick();
      model[31] = 32'hA5A5_A5A5;
      rf.regwrite = 1'b0;
      rf.read_reg1 = 5'd31;
      rf.read_reg2 = 5'd31;
      #1;
      checks++;
      if (rf.read_data1 !== 32'hA5A5_A5A5) begin
         errors++;
         $display("FAIL dual rd1 got=%h exp=%h",
                  rf.read_data1, 32'hA5A5_A5A5);
      end
      checks++;
      if (rf.read_data2 !== 32'hA5A5_A5A5) begin
         errors++;
         $display("FAIL dual rd2 got=%h exp=%h",
                  rf.read_data2, 32'hA5A5_A5A5);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      rf.regwrite = 1'b1;
      rf.write_reg = 5'd7;
      rf.read_reg1 = 5'd7;
      for (int k = 0; k < 3; k++) begin
         v = $urandom;
         rf.write_data = v;
         tick();
         model[7] = v;
         checks++;
         if (rf.read_data1 !== v) begin
            errors++;
            $display("FAIL b2b step=%0d got=%h exp=%h",
                     k, rf.read_data1, v);
         end
      end
      rf.regwrite = 1'b0;
   endtask

   task automatic test_random();
      int r1, r2, wr;
      logic we;
      logic [31:0] wd;
      for (int n = 0; n < 300; n++) begin
         r1 = $urandom_range(0, 31);
         r2 = $urandom_range(0, 31);
         wr = ($urandom_range(0, 3) == 0) ? r1 : $urandom_range(0, 31);
         we = 1'($urandom_range(0, 1));
         wd = $urandom;
         rf.read_reg1 = r1[4:0];
         rf.read_reg2 = r2[4:0];
         rf.write_reg = wr[4:0];
         rf.write_data = wd;
         rf.regwrite = we;
         #1;
         checks++;
         if (rf.read_data1 !== ref_read(r1)) begin
            errors++;
            $display("FAIL rnd_pre rd1 n=%0d idx=%0d got=%h exp=%h",
                     n, r1, rf.read_data1, ref_read(r1));
         end
         checks++;
         if (rf.read_data2 !== ref_read(r2)) begin
            errors++;
            $display("FAIL rnd_pre rd2 n=%0d idx=%0d got=%h exp=%h",
                     n, r2, rf.read_data2, ref_read(r2));
         end
         tick();
         if (we && wr != 0) model[wr] = wd;
         checks++;
         if (rf.read_data1 !== ref_read(r1)) begin
            errors++;
            $display("FAIL rnd_post rd1 n=%0d idx=%0d got=%h exp=%h",
                     n, r1, rf.read_data1, ref_read(r1));
         end
         checks++;
         if (rf.read_data2 !== ref_read(r2)) begin
            errors++;
            $display("FAIL rnd_post rd2 n=%0d idx=%0d got=%h exp=%h",
                     n, r2, rf.read_data2, ref_read(r2));
         end
      end
      rf.regwrite = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      clear_model();
      test_reset();
      test_preload();
      test_write_read();
      test_x0();
      test_write_enable();
      test_dual_read();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
